// File: rtl/mem_rsp_pkg.sv
// Shared types for the memory request responder: FSM states, access sizes, grant sources.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_rsp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACC,
        ST_WAIT,
        ST_RESP,
        ST_RECOV
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_DWR,
        SRC_DRD,
        SRC_IRD
    } src_t;

    typedef struct packed {
        src_t        src;
        size_t       size;
        logic [31:0] adr;
        logic [31:0] wdat;
    } req_t;

    // Word flag wins if a requester ever sets both size flags.
    function automatic size_t dec_size(input logic w, input logic hw);
        if (w)
            return SZ_WORD;
        else if (hw)
            return SZ_HALF;
        else
            return SZ_BYTE;
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatter: write enables, lane-shifted write data, read extraction, misalign detect.
// Latency: purely combinational.
// Backpressure: none; pure function of its inputs.
module mem_lane_fmt
    import mem_rsp_pkg::*;
(
    input  size_t       size,
    input  logic [1:0]  adr_lo,
    input  logic [31:0] wdat,
    input  logic [31:0] ram_rdat,
    output logic [3:0]  we,
    output logic [31:0] wdat_lane,
    output logic [31:0] rdat_fmt,
    output logic        misalign
);

    logic [1:0]  off;
    logic [4:0]  sh;
    logic [31:0] mask;

    always_comb begin
        off      = adr_lo;
        misalign = 1'b0;
        mask     = 32'h0000_00FF;
        we       = 4'b0001 << adr_lo;
        case (size)
            SZ_HALF: begin
                off      = {adr_lo[1], 1'b0};
                misalign = adr_lo[0];
                mask     = 32'h0000_FFFF;
                we       = 4'b0011 << {adr_lo[1], 1'b0};
            end
            SZ_WORD: begin
                off      = 2'b00;
                misalign = |adr_lo;
                mask     = 32'hFFFF_FFFF;
                we       = 4'hF;
            end
            default: ;
        endcase
        sh        = {off, 3'b000};
        wdat_lane = (wdat & mask) << sh;
        rdat_fmt  = (ram_rdat >> sh) & mask;
    end

endmodule

// File: rtl/mem_req_responder.sv
// Arbitrates I-read/D-read/D-write onto one sync RAM; MEM_RSP_WAIT_EN adds WAIT_CYC wait states.
// Latency: response pulse 3 cycles after grant (3+WAIT_CYC with MEM_RSP_WAIT_EN), one access per 4(+WAIT_CYC).
// Backpressure: requests are held levels; no preemption, a dropped request still gets its pulse.
module mem_req_responder
    import mem_rsp_pkg::*;
#(
    parameter int RAM_AW   = 14,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read_req,
    input  logic              i_read_w,
    input  logic              i_read_hw,
    input  logic [31:0]       i_read_adr,
    input  logic              d_read_req,
    input  logic              d_read_w,
    input  logic              d_read_hw,
    input  logic [31:0]       d_read_adr,
    input  logic              d_write_req,
    input  logic              d_write_w,
    input  logic              d_write_hw,
    input  logic [31:0]       d_write_adr,
    input  logic [31:0]       d_write_data,
    output logic              read_valid,
    output logic [31:0]       read_data,
    output logic              write_finish,
    output logic              misalign_err,
    input  logic              err_clr,
    output logic [RAM_AW-1:0] ram_adr,
    output logic [3:0]        ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    state_t      state, state_n;
    src_t        grant;
    req_t        sel_req, req_q;
    logic [3:0]  fmt_we;
    logic [31:0] fmt_wdat, fmt_rdat;
    logic        fmt_misalign;
    logic        unused_bits;

`ifdef MEM_RSP_WAIT_EN
    logic [3:0] wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (state == ST_ACC)
            wait_cnt <= 4'(WAIT_CYC - 1);
        else if (state == ST_WAIT && wait_cnt != '0)
            wait_cnt <= wait_cnt - 4'd1;
    end
`endif

    always_comb begin
        grant   = SRC_NONE;
        sel_req = '0;
        if (d_write_req) begin
            grant        = SRC_DWR;
            sel_req.size = dec_size(d_write_w, d_write_hw);
            sel_req.adr  = d_write_adr;
            sel_req.wdat = d_write_data;
        end else if (d_read_req) begin
            grant        = SRC_DRD;
            sel_req.size = dec_size(d_read_w, d_read_hw);
            sel_req.adr  = d_read_adr;
        end else if (i_read_req) begin
            grant        = SRC_IRD;
            sel_req.size = dec_size(i_read_w, i_read_hw);
            sel_req.adr  = i_read_adr;
        end
        sel_req.src = grant;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (grant != SRC_NONE) state_n = ST_ACC;
`ifdef MEM_RSP_WAIT_EN
            ST_ACC:   state_n = ST_WAIT;
            ST_WAIT:  if (wait_cnt == '0) state_n = ST_RESP;
`else
            ST_ACC:   state_n = ST_RESP;
`endif
            ST_RESP:  state_n = ST_RECOV;
            ST_RECOV: state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    mem_lane_fmt u_lane_fmt (
        .size      (req_q.size),
        .adr_lo    (req_q.adr[1:0]),
        .wdat      (req_q.wdat),
        .ram_rdat  (ram_rdata),
        .we        (fmt_we),
        .wdat_lane (fmt_wdat),
        .rdat_fmt  (fmt_rdat),
        .misalign  (fmt_misalign)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            req_q        <= '0;
            read_valid   <= 1'b0;
            read_data    <= '0;
            write_finish <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_n;
            read_valid   <= (state == ST_RESP) && (req_q.src != SRC_DWR);
            write_finish <= (state == ST_RESP) && (req_q.src == SRC_DWR);
            if (state == ST_IDLE && grant != SRC_NONE)
                req_q <= sel_req;
            if (state == ST_RESP && req_q.src != SRC_DWR)
                read_data <= fmt_rdat;
            // Clear wins over a set landing in the same cycle.
            if (err_clr)
                misalign_err <= 1'b0;
            else if (state == ST_ACC && fmt_misalign)
                misalign_err <= 1'b1;
        end
    end

    // Address is held in req_q, so it stays put from ACC through RESP.
    assign ram_adr     = req_q.adr[RAM_AW+1:2];
    assign ram_we      = (state == ST_ACC && req_q.src == SRC_DWR) ? fmt_we : 4'h0;
    assign ram_wdata   = fmt_wdat;
    assign unused_bits = ^{req_q.adr[31:RAM_AW+2], 4'(WAIT_CYC)};

endmodule

// File: tb/tb_mem_req_responder.sv
// Directed bench for mem_req_responder with a behavioural sync RAM; MEM_RSP_WAIT_EN shifts expected latency.
// Latency: response cycle measured from the sampling edge.
// Backpressure: requests held until the response pulse.
module tb_mem_req_responder;

    localparam int RAM_AW   = 14;
    localparam int WAIT_CYC = 3;
`ifdef MEM_RSP_WAIT_EN
    localparam int LAT = 3 + WAIT_CYC;
`else
    localparam int LAT = 3;
`endif
    localparam int PER = LAT + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_read_req, i_read_w, i_read_hw;
    logic [31:0]       i_read_adr;
    logic              d_read_req, d_read_w, d_read_hw;
    logic [31:0]       d_read_adr;
    logic              d_write_req, d_write_w, d_write_hw;
    logic [31:0]       d_write_adr, d_write_data;
    logic              read_valid;
    logic [31:0]       read_data;
    logic              write_finish;
    logic              misalign_err;
    logic              err_clr;
    logic [RAM_AW-1:0] ram_adr;
    logic [3:0]        ram_we;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata = '0;

    logic [31:0] mem [0:(1<<RAM_AW)-1] = '{default: 32'h0};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (ram_we[b]) mem[ram_adr][8*b +: 8] <= ram_wdata[8*b +: 8];
        ram_rdata <= mem[ram_adr];
    end

    mem_req_responder #(.RAM_AW(RAM_AW), .WAIT_CYC(WAIT_CYC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_read_req   (i_read_req),
        .i_read_w     (i_read_w),
        .i_read_hw    (i_read_hw),
        .i_read_adr   (i_read_adr),
        .d_read_req   (d_read_req),
        .d_read_w     (d_read_w),
        .d_read_hw    (d_read_hw),
        .d_read_adr   (d_read_adr),
        .d_write_req  (d_write_req),
        .d_write_w    (d_write_w),
        .d_write_hw   (d_write_hw),
        .d_write_adr  (d_write_adr),
        .d_write_data (d_write_data),
        .read_valid   (read_valid),
        .read_data    (read_data),
        .write_finish (write_finish),
        .misalign_err (misalign_err),
        .err_clr      (err_clr),
        .ram_adr      (ram_adr),
        .ram_we       (ram_we),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_reqs();
        d_write_req = 1'b0; d_read_req = 1'b0; i_read_req = 1'b0;
    endtask

    // ch: 0 = data write, 1 = data read, 2 = instruction read. Called and returns at a negedge.
    task automatic access(input string tag, input int ch, input logic w, input logic hw,
                          input logic [31:0] adr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic [3:0] we1,
                          output logic [RAM_AW-1:0] a1);
        int   lat;
        logic stable;
        lat = -1; rd = '0; we1 = '0; a1 = '0; stable = 1'b1;
        case (ch)
            0: begin d_write_req = 1'b1; d_write_w = w; d_write_hw = hw; d_write_adr = adr; d_write_data = wd; end
            1: begin d_read_req = 1'b1; d_read_w = w; d_read_hw = hw; d_read_adr = adr; end
            default: begin i_read_req = 1'b1; i_read_w = w; i_read_hw = hw; i_read_adr = adr; end
        endcase
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) begin
                we1 = ram_we;
                a1  = ram_adr;
            end else if (c < LAT && ram_adr !== a1) begin
                stable = 1'b0;
            end
            if ((ch == 0) ? write_finish : read_valid) begin
                lat = c;
                rd  = read_data;
                break;
            end
        end
        clear_reqs();
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_adr_stable"}, {31'b0, stable}, 32'd1);
        @(negedge clk);
        check({tag, "_pulse_width"}, {31'b0, (ch == 0) ? write_finish : read_valid}, 32'd0);
    endtask

    logic [31:0]       rd;
    logic [3:0]        we1;
    logic [RAM_AW-1:0] a1;
    int                wf_c, dr_c, ir_c, nvalid;
    logic [31:0]       dr_d, ir_d;

    initial begin
        rst_n = 1'b0; err_clr = 1'b0;
        clear_reqs();
        i_read_w = 0; i_read_hw = 0; i_read_adr = '0;
        d_read_w = 0; d_read_hw = 0; d_read_adr = '0;
        d_write_w = 0; d_write_hw = 0; d_write_adr = '0; d_write_data = '0;
        repeat (3) @(negedge clk);
        check("rst_read_data", read_data, 32'h0);
        check("rst_flags", {28'b0, read_valid, write_finish, misalign_err, 1'b0}, 32'h0);
        check("rst_ram_we", {28'b0, ram_we}, 32'h0);
        check("rst_ram_adr", {18'b0, ram_adr}, 32'h0);
        check("rst_ram_wdata", ram_wdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        access("wr_word", 0, 1, 0, 32'h100, 32'hDEAD_BEEF, rd, we1, a1);
        check("wr_word_we", {28'b0, we1}, 32'hF);
        check("wr_word_adr", {18'b0, a1}, 32'h40);
        access("rd_word", 1, 1, 0, 32'h100, 32'h0, rd, we1, a1);
        check("rd_word_data", rd, 32'hDEAD_BEEF);
        check("rd_word_we", {28'b0, we1}, 32'h0);

        access("wr_byte", 0, 0, 0, 32'h203, 32'h0000_00A5, rd, we1, a1);
        check("wr_byte_we", {28'b0, we1}, 32'h8);
        access("rd_w200", 1, 1, 0, 32'h200, 32'h0, rd, we1, a1);
        check("rd_w200_data", rd, 32'hA500_0000);
        access("rd_b203", 2, 0, 0, 32'h203, 32'h0, rd, we1, a1);
        check("rd_b203_data", rd, 32'h0000_00A5);

        access("wr_half", 0, 0, 1, 32'h402, 32'hFFFF_1234, rd, we1, a1);
        check("wr_half_we", {28'b0, we1}, 32'hC);
        access("rd_w400", 1, 1, 0, 32'h400, 32'h0, rd, we1, a1);
        check("rd_w400_data", rd, 32'h1234_0000);
        access("rd_h402", 1, 0, 1, 32'h402, 32'h0, rd, we1, a1);
        check("rd_h402_data", rd, 32'h0000_1234);

        access("rd_upper", 2, 1, 0, 32'h8000_0100, 32'h0, rd, we1, a1);
        check("rd_upper_data", rd, 32'hDEAD_BEEF);
        check("rd_upper_adr", {18'b0, a1}, 32'h40);
        check("aligned_no_err", {31'b0, misalign_err}, 32'd0);

        access("rd_h101", 1, 0, 1, 32'h101, 32'h0, rd, we1, a1);
        check("rd_h101_data", rd, 32'h0000_BEEF);
        check("misalign_set", {31'b0, misalign_err}, 32'd1);
        repeat (3) @(negedge clk);
        check("misalign_sticky", {31'b0, misalign_err}, 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("misalign_clr", {31'b0, misalign_err}, 32'd0);

        err_clr = 1'b1;
        access("rd_w102", 1, 1, 0, 32'h102, 32'h0, rd, we1, a1);
        err_clr = 1'b0;
        check("rd_w102_data", rd, 32'hDEAD_BEEF);
        check("misalign_clr_priority", {31'b0, misalign_err}, 32'd0);

        // All three channels held together.
        wf_c = -1; dr_c = -1; ir_c = -1; dr_d = '0; ir_d = '0;
        d_write_req = 1; d_write_w = 1; d_write_hw = 0; d_write_adr = 32'h300; d_write_data = 32'h1122_3344;
        d_read_req  = 1; d_read_w  = 1; d_read_hw  = 0; d_read_adr  = 32'h300;
        i_read_req  = 1; i_read_w  = 1; i_read_hw  = 0; i_read_adr  = 32'h100;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (write_finish) begin wf_c = c; d_write_req = 1'b0; end
            if (read_valid) begin
                if (dr_c < 0) begin dr_c = c; dr_d = read_data; d_read_req = 1'b0; end
                else begin ir_c = c; ir_d = read_data; i_read_req = 1'b0; break; end
            end
        end
        clear_reqs();
        check("arb_write_cycle", wf_c, LAT);
        check("arb_dread_cycle", dr_c, LAT + PER);
        check("arb_dread_data", dr_d, 32'h1122_3344);
        check("arb_iread_cycle", ir_c, LAT + 2 * PER);
        check("arb_iread_data", ir_d, 32'hDEAD_BEEF);
        @(negedge clk);

        // Reset during ACC of a read.
        d_read_req = 1'b1; d_read_w = 1'b1; d_read_hw = 1'b0; d_read_adr = 32'h100;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_read_data", read_data, 32'h0);
        check("mid_rst_flags", {28'b0, read_valid, write_finish, misalign_err, 1'b0}, 32'h0);
        check("mid_rst_ram", {14'b0, ram_adr, ram_we}, 32'h0);
        d_read_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        nvalid = 0;
        repeat (8) begin
            @(negedge clk);
            if (read_valid) nvalid++;
        end
        check("mid_rst_no_pulse", nvalid, 0);
        access("post_rst", 1, 1, 0, 32'h300, 32'h0, rd, we1, a1);
        check("post_rst_data", rd, 32'h1122_3344);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
